sseg_mux_n: RTL
===============

# sseg_mux_n

Parametrised N-digit multiplexed seven-segment driver for the board display, successor to the fixed 8-digit scanner. It shows a packed hex word on DIGITS common-anode digits with per-digit decimal points, per-digit blanking, optional leading-zero suppression and 16-level PWM brightness. A frame-coherent shadow copy of the inputs prevents digit tearing. Anode and cathode outputs are registered together, so there is no one-slot skew between them. It sits between the CPU debug/status registers and the top-level SSEG pins.

## Interface
- DIGITS, 8: number of digits, 1..16.
- SCAN_DIV, 16384: clocks per digit slot in normal mode. Must be a multiple of 16 and at least 16.
- CLK  in  1  system clock; all logic on rising edge.
- RST_N  in  1  asynchronous active-low reset.
- DEBUG  in  1  when 1, slot length is 1 clock (fast scan for simulation/probing); brightness is ignored.
- VALUE  in  4*DIGITS  hex nibbles; nibble i (VALUE[4i+3:4i]) drives digit i, and digit DIGITS-1 is leftmost.
- DP_EN  in  DIGITS  bit i lights the decimal point of digit i.
- BLANK  in  DIGITS  bit i forces digit i dark (anode inactive).
- LZ_SUPPRESS  in  1  enables leading-zero blanking.
- BRIGHT  in  4  duty level; 15 is full, 0 is 1/16.
- SSEG_CA  out  8  active-low cathodes {dp,g,f,e,d,c,b,a}.
- SSEG_AN  out  DIGITS  active-low anodes; bit i selects digit i.
- FRAME_DONE  out  1  one-cycle pulse at the end of every full scan.

## Operation
- State:
  - slot_cnt counts 0..SCAN_DIV-1, or stays at 0 when DEBUG=1.
  - idx is the digit index.
  - Shadows: sh_val, sh_dp, sh_blank.
- Slot end: the cycle where DEBUG=1 or slot_cnt==SCAN_DIV-1. On slot end, slot_cnt←0 and idx advances.
- Scan order: idx steps DIGITS-1, DIGITS-2, …, 0, then wraps to DIGITS-1.
- Snapshot: on the slot end of idx==0, load the shadows from VALUE/DP_EN/BLANK. In the same cycle FRAME_DONE=1. Inputs are sampled only here.
- Leading-zero rule: digit i is suppressed iff all of the following hold:
  - LZ_SUPPRESS=1;
  - i≠0;
  - every shadow nibble j with i≤j≤DIGITS-1 is 0.
  - Digit 0 is never suppressed. LZ_SUPPRESS is sampled live, not shadowed.
- Digit dark: sh_blank[idx] OR suppressed.
- Segment encoding (dp bit=1) for 0..F: C0 F9 A4 B0 99 92 82 F8 80 90 88 83 C6 A1 86 8E. SSEG_CA[7]=~sh_dp[idx]. A dark digit drives SSEG_CA=FF.
- Anode: SSEG_AN bit idx=0, all other bits 1, when all of the following hold:
  - the digit is not dark;
  - DEBUG=1, or (slot_cnt mod 16) ≤ BRIGHT.
  - Otherwise SSEG_AN is all ones.
- DEBUG and BRIGHT take effect on the next clock. No frame restart.

## Timing
- Reset (asynchronous, RST_N=0) values:
  - SSEG_AN all ones, SSEG_CA=FF, FRAME_DONE=0;
  - idx=DIGITS-1, slot_cnt=0;
  - all shadows 0 (the first frame after reset shows zeros).
- SSEG_CA/SSEG_AN are registered, computed from the post-edge idx/slot_cnt/shadow values. Anode and cathode always change on the same edge.
- Frame length: DIGITS*SCAN_DIV clocks normal, DIGITS clocks in DEBUG.
- VALUE→display latency: visible in the frame after the next snapshot, worst case 2 frames.
- Input change in the same cycle as a snapshot: the new value is captured (sampled at that edge).
- DEBUG toggled mid-slot: the slot ends at the next edge if DEBUG=1. If DEBUG falls, counting resumes from 0.
- DIGITS=1: idx is constant 0, every slot end is a frame end, and FRAME_DONE pulses every slot.
- Reset mid-frame: immediate return to reset values. No partial FRAME_DONE.

## Test plan
- Reset, DEBUG=1, DIGITS=8, VALUE=32'h0123ABCD, BRIGHT=15:
  - After the first FRAME_DONE, the next 8 cycles give AN=7F,BF,DF,EF,F7,FB,FD,FE with CA=C0,F9,A4,B0,88,83,C6,A1.
  - FRAME_DONE pulses every 8 clocks.
- LZ_SUPPRESS=1, VALUE=32'h00000050, DEBUG=1:
  - Digits 7..2 are dark (AN=FF, CA=FF).
  - Digit 1 shows 5 (92), digit 0 shows 0 (C0).
  - With VALUE=0, only digit 0 lights.
- DP_EN=8'h01, BLANK=8'h80, DEBUG=1:
  - Digit 0 CA has bit7=0 (e.g. 0→40).
  - Digit 7 is dark.
  - The other digits are unchanged.
- DEBUG=0, SCAN_DIV=32, BRIGHT=3, DIGITS=4:
  - Each slot lasts 32 clocks.
  - The anode is low for slot_cnt mod 16 ∈ 0..3 (8 of 32 clocks).
  - CA is stable for the whole slot.
- Change VALUE in the middle of a frame: no digit of the current frame changes, and the new value appears starting with the first slot after FRAME_DONE.
- Assert RST_N=0 in the middle of slot 3: outputs go to AN all ones and CA=FF asynchronously. On release, the scan restarts at idx=DIGITS-1 showing 0.

Source files
------------

// File: rtl/sseg_mux_n_if.sv
// ---------------------------------------------------------------------------
// sseg_mux_n_if : display data in / SSEG pins out for the N-digit scanner
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface sseg_mux_n_if #(
  parameter int DIGITS = 8
);
  logic [4*DIGITS-1:0] value_i;
  logic [DIGITS-1:0]   dp_en_i;
  logic [DIGITS-1:0]   blank_i;
  logic                lz_suppress_i;
  logic [3:0]          bright_i;
  logic                debug_i;
  logic [7:0]          sseg_ca_o;
  logic [DIGITS-1:0]   sseg_an_o;
  logic                frame_done_o;

  modport master (
    output value_i, dp_en_i, blank_i, lz_suppress_i, bright_i, debug_i,
    input  sseg_ca_o, sseg_an_o, frame_done_o
  );

  modport slave (
    input  value_i, dp_en_i, blank_i, lz_suppress_i, bright_i, debug_i,
    output sseg_ca_o, sseg_an_o, frame_done_o
  );
endinterface

`default_nettype wire

// File: rtl/sseg_mux_n.sv
// ---------------------------------------------------------------------------
// sseg_mux_n : N-digit multiplexed seven-segment driver with frame shadowing
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sseg_mux_n #(
  parameter int DIGITS   = 8,
  parameter int SCAN_DIV = 16384
) (
  input  logic        clk,
  input  logic        rst_n,
  sseg_mux_n_if.slave bus
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CNT_W = $clog2(SCAN_DIV);

  localparam logic [IDX_W-1:0] C_IDX_LAST = IDX_W'(DIGITS - 1);
  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(SCAN_DIV - 1);

  logic [CNT_W-1:0]    slot_cnt_q, slot_cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [4*DIGITS-1:0] sh_val_q, sh_val_d;
  logic [DIGITS-1:0]   sh_dp_q, sh_dp_d;
  logic [DIGITS-1:0]   sh_blank_q, sh_blank_d;
  logic [7:0]          ca_q, ca_d;
  logic [DIGITS-1:0]   an_q, an_d;

  logic                w_slot_end;
  logic                w_snap;
  logic [DIGITS-1:0]   w_zero_from;
  logic [3:0]          w_nib;
  logic                w_dp;
  logic                w_blank;
  logic                w_sup;
  logic                w_dark;
  logic                w_lit;

  function automatic logic [6:0] seg_lut(input logic [3:0] n);
    logic [7:0] s;
    case (n)
      4'h0: s = 8'hC0;
      4'h1: s = 8'hF9;
      4'h2: s = 8'hA4;
      4'h3: s = 8'hB0;
      4'h4: s = 8'h99;
      4'h5: s = 8'h92;
      4'h6: s = 8'h82;
      4'h7: s = 8'hF8;
      4'h8: s = 8'h80;
      4'h9: s = 8'h90;
      4'hA: s = 8'h88;
      4'hB: s = 8'h83;
      4'hC: s = 8'hC6;
      4'hD: s = 8'hA1;
      4'hE: s = 8'h86;
      default: s = 8'h8E;
    endcase
    return s[6:0];
  endfunction

  // Scan sequencing; shadows reload only at the frame boundary.
  always_comb begin
    w_slot_end = bus.debug_i || (slot_cnt_q == C_CNT_LAST);
    w_snap     = w_slot_end && (idx_q == '0);
    slot_cnt_d = w_slot_end ? '0 : slot_cnt_q + 1'b1;
    if (!w_slot_end) begin
      idx_d = idx_q;
    end else if (idx_q == '0) begin
      idx_d = C_IDX_LAST;
    end else begin
      idx_d = idx_q - 1'b1;
    end
    sh_val_d   = w_snap ? bus.value_i : sh_val_q;
    sh_dp_d    = w_snap ? bus.dp_en_i : sh_dp_q;
    sh_blank_d = w_snap ? bus.blank_i : sh_blank_q;
  end

  // w_zero_from[i]: every shadow nibble from i up to the leftmost digit is 0.
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_lz
    assign w_zero_from[gi] = ~|sh_val_d[4*DIGITS-1:4*gi];
  end

  always_comb begin
    w_nib   = '0;
    w_dp    = 1'b0;
    w_blank = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_d == IDX_W'(i)) begin
        w_nib   = sh_val_d[4*i +: 4];
        w_dp    = sh_dp_d[i];
        w_blank = sh_blank_d[i];
      end
    end
    w_sup  = bus.lz_suppress_i && (idx_d != '0) && w_zero_from[idx_d];
    w_dark = w_blank || w_sup;
    w_lit  = !w_dark && (bus.debug_i || (slot_cnt_d[3:0] <= bus.bright_i));
    ca_d   = w_dark ? 8'hFF : {~w_dp, seg_lut(w_nib)};
    an_d   = w_lit ? ~(DIGITS'(1) << idx_d) : '1;
  end

  // Outputs are derived from the post-edge scan state so anode and cathode move together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_cnt_q <= '0;
      idx_q      <= C_IDX_LAST;
      sh_val_q   <= '0;
      sh_dp_q    <= '0;
      sh_blank_q <= '0;
      ca_q       <= 8'hFF;
      an_q       <= '1;
    end else begin
      slot_cnt_q <= slot_cnt_d;
      idx_q      <= idx_d;
      sh_val_q   <= sh_val_d;
      sh_dp_q    <= sh_dp_d;
      sh_blank_q <= sh_blank_d;
      ca_q       <= ca_d;
      an_q       <= an_d;
    end
  end

  assign bus.sseg_ca_o    = ca_q;
  assign bus.sseg_an_o    = an_q;
  assign bus.frame_done_o = w_snap;

endmodule

`default_nettype wire
